// File: rtl/can_cfg_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : can_cfg_sequencer_if
// Description : Command and register/TX-buffer write bus of the CAN config
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface can_cfg_sequencer_if;
    logic         cfg_start_i;
    logic [31:0]  btr_i;
    logic [31:0]  btr_fd_i;
    logic [7:0]   mode_i;
    logic [15:0]  bit_cycles_i;
    logic         tx_req_i;
    logic [3:0]   tx_len_i;
    logic [103:0] tx_frame_i;

    logic         cfg_busy_o;
    logic         ready_o;
    logic         tx_busy_o;
    logic         tx_ack_o;
    logic         err_o;
    logic         reg_we_o;
    logic [7:0]   reg_addr_write_o;
    logic [31:0]  reg_data_o;
    logic         tx_we_o;
    logic [3:0]   tx_addr_o;
    logic [7:0]   tx_data_o;

    modport master (
        input  cfg_start_i, btr_i, btr_fd_i, mode_i, bit_cycles_i,
               tx_req_i, tx_len_i, tx_frame_i,
        output cfg_busy_o, ready_o, tx_busy_o, tx_ack_o, err_o,
               reg_we_o, reg_addr_write_o, reg_data_o,
               tx_we_o, tx_addr_o, tx_data_o
    );

    modport slave (
        output cfg_start_i, btr_i, btr_fd_i, mode_i, bit_cycles_i,
               tx_req_i, tx_len_i, tx_frame_i,
        input  cfg_busy_o, ready_o, tx_busy_o, tx_ack_o, err_o,
               reg_we_o, reg_addr_write_o, reg_data_o,
               tx_we_o, tx_addr_o, tx_data_o
    );
endinterface
`default_nettype wire

// File: rtl/can_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : can_cfg_sequencer
// Description : Programs mode/bit-timing of a can_top_raw core, waits 11 bit
//               times for bus idle, then loads and launches TX frames.
// Revision    : 1.0 - initial release
// ============================================================================
module can_cfg_sequencer #(
    parameter logic [7:0] MODE_ADDR    = 8'd0,
    parameter logic [7:0] CMD_ADDR     = 8'd1,
    parameter logic [7:0] BTR_ADDR     = 8'd6,
    parameter logic [7:0] BTR_FD_ADDR  = 8'd7,
    parameter int         MAX_TX_BYTES = 13
) (
    input  wire logic           clk_i,
    input  wire logic           rst_i,
    can_cfg_sequencer_if.master bus
);

    localparam logic [3:0] c_IDLE       = 4'd0;
    localparam logic [3:0] c_CFG_RST    = 4'd1;
    localparam logic [3:0] c_CFG_BTR    = 4'd2;
    localparam logic [3:0] c_CFG_BTR_FD = 4'd3;
    localparam logic [3:0] c_CFG_RUN    = 4'd4;
    localparam logic [3:0] c_WAIT_IDLE  = 4'd5;
    localparam logic [3:0] c_READY      = 4'd6;
    localparam logic [3:0] c_TX_LOAD    = 4'd7;
    localparam logic [3:0] c_TX_CMD     = 4'd8;

    localparam int         c_FRAME_BYTES = 13;
    localparam logic [3:0] c_MAX_LEN     = 4'(MAX_TX_BYTES);

    logic [3:0]   state_q, state_d;
    logic [31:0]  btr_q, btr_d;
    logic [31:0]  btr_fd_q, btr_fd_d;
    logic [7:0]   mode_q, mode_d;
    logic [15:0]  bit_cycles_q, bit_cycles_d;
    logic [19:0]  wait_cnt_q, wait_cnt_d;
    logic [103:0] frame_q, frame_d;
    logic [3:0]   len_q, len_d;
    logic [3:0]   idx_q, idx_d;
    logic         err_q, err_d;

    logic         w_in_wait;
    logic         w_wait_done;
    logic         w_ready;
    logic         w_cfg_phase;
    logic         w_len_ok;
    logic         w_cfg_go;
    logic         w_tx_go;
    logic [19:0]  w_wait_load;
    logic [7:0]   w_tx_byte;

    // Last idle-wait cycle already counts as ready, so ready_o rises exactly
    // 11 bit times after the run-mode write and requests are accepted there.
    assign w_in_wait   = (state_q == c_WAIT_IDLE);
    assign w_wait_done = w_in_wait && (wait_cnt_q == 20'd0);
    assign w_ready     = (state_q == c_READY) || w_wait_done;
    assign w_cfg_phase = (state_q == c_CFG_RST) || (state_q == c_CFG_BTR) ||
                         (state_q == c_CFG_BTR_FD) || (state_q == c_CFG_RUN);

    assign w_len_ok = (bus.tx_len_i != 4'd0) && (bus.tx_len_i <= c_MAX_LEN);
    assign w_cfg_go = bus.cfg_start_i && ((state_q == c_IDLE) || w_ready);
    assign w_tx_go  = bus.tx_req_i && w_ready && w_len_ok && !bus.cfg_start_i;

    assign w_wait_load = (bit_cycles_q == 16'd0) ? 20'd0
                       : (({4'd0, bit_cycles_q} * 20'd11) - 20'd1);

    always_comb begin
        w_tx_byte = 8'd0;
        for (int k = 0; k < c_FRAME_BYTES; k++) begin
            if (idx_q == 4'(k)) w_tx_byte = frame_q[8*k +: 8];
        end
    end

    always_comb begin
        state_d      = state_q;
        btr_d        = btr_q;
        btr_fd_d     = btr_fd_q;
        mode_d       = mode_q;
        bit_cycles_d = bit_cycles_q;
        wait_cnt_d   = wait_cnt_q;
        frame_d      = frame_q;
        len_d        = len_q;
        idx_d        = idx_q;
        err_d        = (bus.tx_req_i && !w_tx_go) || (bus.cfg_start_i && !w_cfg_go);

        if (w_cfg_go) begin
            state_d      = c_CFG_RST;
            btr_d        = bus.btr_i;
            btr_fd_d     = bus.btr_fd_i;
            mode_d       = bus.mode_i;
            bit_cycles_d = bus.bit_cycles_i;
        end else if (w_tx_go) begin
            state_d = c_TX_LOAD;
            frame_d = bus.tx_frame_i;
            len_d   = bus.tx_len_i;
            idx_d   = 4'd0;
        end else begin
            case (state_q)
                c_IDLE:       state_d = c_IDLE;
                c_CFG_RST:    state_d = c_CFG_BTR;
                c_CFG_BTR:    state_d = c_CFG_BTR_FD;
                c_CFG_BTR_FD: state_d = c_CFG_RUN;
                c_CFG_RUN: begin
                    state_d    = c_WAIT_IDLE;
                    wait_cnt_d = w_wait_load;
                end
                c_WAIT_IDLE: begin
                    if (wait_cnt_q == 20'd0) state_d = c_READY;
                    else                     wait_cnt_d = wait_cnt_q - 20'd1;
                end
                c_READY:      state_d = c_READY;
                c_TX_LOAD: begin
                    if (idx_q == (len_q - 4'd1)) state_d = c_TX_CMD;
                    else                         idx_d   = idx_q + 4'd1;
                end
                c_TX_CMD:     state_d = c_READY;
                default:      state_d = c_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= c_IDLE;
            btr_q        <= 32'd0;
            btr_fd_q     <= 32'd0;
            mode_q       <= 8'd0;
            bit_cycles_q <= 16'd0;
            wait_cnt_q   <= 20'd0;
            frame_q      <= 104'd0;
            len_q        <= 4'd0;
            idx_q        <= 4'd0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            btr_q        <= btr_d;
            btr_fd_q     <= btr_fd_d;
            mode_q       <= mode_d;
            bit_cycles_q <= bit_cycles_d;
            wait_cnt_q   <= wait_cnt_d;
            frame_q      <= frame_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            err_q        <= err_d;
        end
    end

    // Strobes decode straight from state so an async reset silences them at once.
    always_comb begin
        bus.reg_we_o         = 1'b0;
        bus.reg_addr_write_o = 8'd0;
        bus.reg_data_o       = 32'd0;
        bus.tx_we_o          = 1'b0;
        bus.tx_addr_o        = 4'd0;
        bus.tx_data_o        = 8'd0;
        bus.tx_ack_o         = 1'b0;
        case (state_q)
            c_CFG_RST: begin
                bus.reg_we_o         = 1'b1;
                bus.reg_addr_write_o = MODE_ADDR;
                bus.reg_data_o       = 32'h1;
            end
            c_CFG_BTR: begin
                bus.reg_we_o         = 1'b1;
                bus.reg_addr_write_o = BTR_ADDR;
                bus.reg_data_o       = btr_q;
            end
            c_CFG_BTR_FD: begin
                bus.reg_we_o         = 1'b1;
                bus.reg_addr_write_o = BTR_FD_ADDR;
                bus.reg_data_o       = btr_fd_q;
            end
            c_CFG_RUN: begin
                bus.reg_we_o         = 1'b1;
                bus.reg_addr_write_o = MODE_ADDR;
                bus.reg_data_o       = {24'd0, mode_q & 8'hFE};
            end
            c_TX_LOAD: begin
                bus.tx_we_o   = 1'b1;
                bus.tx_addr_o = idx_q;
                bus.tx_data_o = w_tx_byte;
            end
            c_TX_CMD: begin
                bus.reg_we_o         = 1'b1;
                bus.reg_addr_write_o = CMD_ADDR;
                bus.reg_data_o       = 32'h1;
                bus.tx_ack_o         = 1'b1;
            end
            default: ;
        endcase
    end

    assign bus.ready_o    = w_ready;
    assign bus.cfg_busy_o = w_cfg_phase || (w_in_wait && !w_wait_done);
    assign bus.tx_busy_o  = (state_q == c_TX_LOAD) || (state_q == c_TX_CMD);
    assign bus.err_o      = err_q;

endmodule
`default_nettype wire

// File: tb/tb_can_cfg_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_can_cfg_sequencer
// Description : Directed + randomized bench for can_cfg_sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_can_cfg_sequencer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    can_cfg_sequencer_if bus();

    can_cfg_sequencer dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    typedef struct {
        int          c;
        logic [7:0]  a;
        logic [31:0] d;
    } wr_t;

    int   cyc = 0;
    wr_t  reg_q[$];
    wr_t  tx_q[$];
    int   err_q[$];
    int   ack_q[$];
    int   rise_q[$];
    int   viol = 0;
    logic ready_prev = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        wr_t w;
        if (rst) begin
            ready_prev = 1'b0;
        end else begin
            if (bus.reg_we_o) begin
                w.c = cyc; w.a = bus.reg_addr_write_o; w.d = bus.reg_data_o;
                reg_q.push_back(w);
            end else if (bus.reg_addr_write_o != 8'd0 || bus.reg_data_o != 32'd0) viol++;
            if (bus.tx_we_o) begin
                w.c = cyc; w.a = {4'd0, bus.tx_addr_o}; w.d = {24'd0, bus.tx_data_o};
                tx_q.push_back(w);
            end else if (bus.tx_addr_o != 4'd0 || bus.tx_data_o != 8'd0) viol++;
            if (bus.reg_we_o && bus.tx_we_o) viol++;
            if ($countones({bus.ready_o, bus.cfg_busy_o, bus.tx_busy_o}) > 1) viol++;
            if (bus.tx_ack_o && !(bus.reg_we_o && bus.reg_addr_write_o == 8'd1)) viol++;
            if (bus.err_o)   err_q.push_back(cyc);
            if (bus.tx_ack_o) ack_q.push_back(cyc);
            if (bus.ready_o && !ready_prev) rise_q.push_back(cyc);
            ready_prev = bus.ready_o;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic clear_logs();
        reg_q.delete(); tx_q.delete(); err_q.delete(); ack_q.delete(); rise_q.delete();
    endtask

    // Configuration: expect four writes on cycles s+1..s+4 and ready_o rising
    // max(11*N,1) cycles after the run-mode write.
    task automatic do_cfg(input logic [31:0] b, input logic [31:0] f, input logic [7:0] m,
                          input logic [15:0] n, input int poke, input bit with_tx);
        int s, budget, exp_wait, exp_err;
        logic [7:0]  ea [4];
        logic [31:0] ed [4];
        clear_logs();
        bus.btr_i = b; bus.btr_fd_i = f; bus.mode_i = m; bus.bit_cycles_i = n;
        bus.cfg_start_i = 1'b1;
        if (with_tx) begin
            bus.tx_req_i = 1'b1; bus.tx_len_i = 4'd3;
        end
        s = cyc;
        tick();
        bus.cfg_start_i = 1'b0; bus.tx_req_i = 1'b0;
        bus.btr_i = $urandom; bus.btr_fd_i = $urandom; bus.mode_i = 8'($urandom);
        bus.bit_cycles_i = 16'($urandom);
        chk("cfg_ready_drop", {63'd0, bus.ready_o}, 64'd0);
        chk("cfg_busy_high", {63'd0, bus.cfg_busy_o}, 64'd1);
        if (poke > 0) begin
            repeat (poke - 1) tick();
            bus.cfg_start_i = 1'b1;
            tick();
            bus.cfg_start_i = 1'b0;
        end
        budget = 11 * int'(n) + 50;
        while (rise_q.size() == 0 && budget > 0) begin tick(); budget--; end
        chk("cfg_ready_seen", {63'd0, rise_q.size() > 0}, 64'd1);
        exp_wait = (n == 16'd0) ? 1 : 11 * int'(n);
        ea = '{8'd0, 8'd6, 8'd7, 8'd0};
        ed = '{32'h1, b, f, {24'd0, m[7:1], 1'b0}};
        chk("cfg_write_count", 64'(reg_q.size()), 64'd4);
        if (reg_q.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                chk("cfg_write_cycle", 64'(reg_q[k].c), 64'(s + 1 + k));
                chk("cfg_write_addr", 64'(reg_q[k].a), 64'(ea[k]));
                chk("cfg_write_data", 64'(reg_q[k].d), 64'(ed[k]));
            end
        end
        if (rise_q.size() > 0) chk("cfg_ready_cycle", 64'(rise_q[0]), 64'(s + 4 + exp_wait));
        exp_err = (poke > 0 ? 1 : 0) + (with_tx ? 1 : 0);
        chk("cfg_err_count", 64'(err_q.size()), 64'(exp_err));
        if (with_tx && err_q.size() > 0) chk("cfg_err_cycle", 64'(err_q[0]), 64'(s + 1));
        chk("cfg_no_tx_writes", 64'(tx_q.size()), 64'd0);
        tick();
    endtask

    task automatic do_tx(input logic [3:0] len, input logic [103:0] frame);
        int s, budget;
        logic [7:0] exp_byte;
        clear_logs();
        bus.tx_req_i = 1'b1; bus.tx_len_i = len; bus.tx_frame_i = frame;
        s = cyc;
        tick();
        bus.tx_req_i = 1'b0; bus.tx_len_i = 4'($urandom); bus.tx_frame_i = {4{$urandom}};
        chk("tx_busy_high", {62'd0, bus.tx_busy_o, bus.ready_o}, 64'd2);
        budget = 40;
        while (ack_q.size() == 0 && budget > 0) begin tick(); budget--; end
        tick();
        chk("tx_ack_count", 64'(ack_q.size()), 64'd1);
        chk("tx_write_count", 64'(tx_q.size()), 64'(len));
        if (tx_q.size() == int'(len)) begin
            for (int k = 0; k < int'(len); k++) begin
                exp_byte = frame[8*k +: 8];
                chk("tx_write_cycle", 64'(tx_q[k].c), 64'(s + 1 + k));
                chk("tx_write_addr", 64'(tx_q[k].a), 64'(k));
                chk("tx_write_data", 64'(tx_q[k].d), 64'(exp_byte));
            end
        end
        chk("tx_cmd_count", 64'(reg_q.size()), 64'd1);
        if (reg_q.size() == 1) begin
            chk("tx_cmd_write", {24'd0, reg_q[0].a, reg_q[0].d}, {24'd0, 8'd1, 32'h1});
            chk("tx_cmd_cycle", 64'(reg_q[0].c), 64'(s + 1 + int'(len)));
        end
        if (ack_q.size() == 1) chk("tx_ack_cycle", 64'(ack_q[0]), 64'(s + 1 + int'(len)));
        chk("tx_ready_back", 64'(rise_q.size() > 0 ? rise_q[0] : -1), 64'(s + 2 + int'(len)));
        chk("tx_no_err", 64'(err_q.size()), 64'd0);
    endtask

    task automatic do_reject(input logic [3:0] len);
        int s;
        logic pre;
        clear_logs();
        pre = bus.ready_o;
        bus.tx_req_i = 1'b1; bus.tx_len_i = len; bus.tx_frame_i = {4{$urandom}};
        s = cyc;
        tick();
        bus.tx_req_i = 1'b0;
        tick(); tick();
        chk("rej_err_count", 64'(err_q.size()), 64'd1);
        if (err_q.size() == 1) chk("rej_err_cycle", 64'(err_q[0]), 64'(s + 1));
        chk("rej_no_writes", 64'(reg_q.size() + tx_q.size()), 64'd0);
        chk("rej_ready_kept", {63'd0, bus.ready_o}, {63'd0, pre});
    endtask

    function automatic logic [103:0] rand_frame();
        logic [127:0] r;
        r = {$urandom, $urandom, $urandom, $urandom};
        return r[103:0];
    endfunction

    initial begin
        int budget;
        logic [3:0] rlen;
        bus.cfg_start_i = 1'b0; bus.btr_i = '0; bus.btr_fd_i = '0; bus.mode_i = '0;
        bus.bit_cycles_i = '0; bus.tx_req_i = 1'b0; bus.tx_len_i = '0; bus.tx_frame_i = '0;
        #1;
        chk("reset_outputs", {bus.cfg_busy_o, bus.ready_o, bus.tx_busy_o, bus.tx_ack_o,
            bus.err_o, bus.reg_we_o, bus.tx_we_o, bus.reg_addr_write_o, bus.tx_addr_o,
            bus.tx_data_o, 24'd0}, 64'd0);
        tick(); tick();
        rst = 1'b0;
        tick();

        do_reject(4'd5);

        do_cfg(32'h2A12491D, 32'h0A04491D, 8'h09, 16'd200, 0, 1'b0);
        do_tx(4'd13, {8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01,
                      8'h78, 8'h56, 8'h34, 8'h12, 8'h88});
        for (int i = 0; i < 4; i++) begin
            rlen = 4'($urandom_range(1, 13));
            do_tx(rlen, rand_frame());
        end
        do_reject(4'd0);
        do_reject(4'd14);
        do_reject(4'd15);

        do_cfg($urandom, $urandom, 8'($urandom), 16'($urandom_range(1, 6)), 6, 1'b0);
        do_cfg($urandom, $urandom, 8'($urandom), 16'($urandom_range(1, 6)), 0, 1'b1);
        do_tx(4'($urandom_range(1, 13)), rand_frame());
        do_cfg($urandom, $urandom, 8'($urandom), 16'd0, 0, 1'b0);

        clear_logs();
        bus.tx_req_i = 1'b1; bus.tx_len_i = 4'd13; bus.tx_frame_i = rand_frame();
        tick();
        bus.tx_req_i = 1'b0;
        budget = 30;
        while (tx_q.size() < 5 && budget > 0) begin tick(); budget--; end
        chk("midtx_reached", 64'(tx_q.size()), 64'd5);
        rst = 1'b1;
        #1;
        chk("midtx_rst_outputs", {bus.cfg_busy_o, bus.ready_o, bus.tx_busy_o, bus.tx_ack_o,
            bus.err_o, bus.reg_we_o, bus.tx_we_o, bus.reg_addr_write_o, bus.tx_addr_o,
            bus.tx_data_o, 24'd0}, 64'd0);
        chk("midtx_rst_data", 64'(bus.reg_data_o), 64'd0);
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("midtx_no_more_tx", 64'(tx_q.size()), 64'd5);
        chk("midtx_idle", {61'd0, bus.ready_o, bus.cfg_busy_o, bus.tx_busy_o}, 64'd0);
        do_reject(4'd4);

        do_cfg($urandom, $urandom, 8'($urandom), 16'($urandom_range(1, 4)), 0, 1'b0);
        do_tx(4'd1, rand_frame());

        chk("invariants", 64'(viol), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/can_cfg_sequencer.md
Name: can_cfg_sequencer

Overview:
Host-side sequencer for one can_top_raw controller (SJA1000-style FD-tolerant/receiver core).
- On command, it programs mode and both bus-timing registers (nominal at addr 6, FD at addr 7).
- It then waits 11 nominal bit times for bus idle before declaring the controller ready.
- Afterwards it loads TX frames byte-wise into the TX buffer and issues the transmit command, replacing manual task-driven register pokes.

Parameters:
MODE_ADDR, 8'd0, register address of mode register
CMD_ADDR, 8'd1, register address of command register
BTR_ADDR, 8'd6, nominal bus-timing register address
BTR_FD_ADDR, 8'd7, data-phase bus-timing register address
MAX_TX_BYTES, 13, largest legal TX frame (frame info + 4 ID + 8 data)

Ports:
clk_i  in  1  system clock
rst_i  in  1  asynchronous active-high reset
cfg_start_i  in  1  pulse: start configuration sequence
btr_i  in  32  nominal timing word ({tsamp,sjw,brp,ps2,ps1,prop})
btr_fd_i  in  32  FD timing word
mode_i  in  8  operating-mode value; bit0 (reset-mode) forced 0 when written
bit_cycles_i  in  16  clk cycles per nominal bit
tx_req_i  in  1  pulse: transmit frame
tx_len_i  in  4  bytes to load, 1..MAX_TX_BYTES
tx_frame_i  in  104  byte k at [8k+7:8k]
cfg_busy_o  out  1  configuration/idle-wait in progress
ready_o  out  1  controller configured, sequencer idle
tx_busy_o  out  1  TX load in progress
tx_ack_o  out  1  one-cycle pulse: transmit command issued
err_o  out  1  one-cycle pulse: rejected request
reg_we_o  out  1  register write strobe
reg_addr_write_o  out  8  register write address
reg_data_o  out  32  register write data
tx_we_o  out  1  TX buffer write strobe
tx_addr_o  out  4  TX buffer address
tx_data_o  out  8  TX buffer data

Behaviour:
- Reset (async, rst_i=1): state IDLE. All outputs 0, counters cleared, latched inputs cleared. Reset mid-sequence aborts immediately with no further strobes.
- States: IDLE, CFG_RST, CFG_BTR, CFG_BTR_FD, CFG_RUN, WAIT_IDLE, READY, TX_LOAD, TX_CMD.
- Strobe timing:
  - Every write state holds its strobe high for exactly one cycle and advances next cycle; writes are back-to-back.
  - Address and data outputs are valid only while the strobe is high and are driven 0 otherwise.
- IDLE/READY + cfg_start_i:
  - Latch btr_i, btr_fd_i, mode_i and bit_cycles_i.
  - cfg_busy_o=1 and ready_o=0 from the next cycle.
- Configuration writes (cycle 0 = start pulse):
  - cycle 1: CFG_RST writes MODE_ADDR, 32'h1.
  - cycle 2: CFG_BTR writes BTR_ADDR, btr.
  - cycle 3: CFG_BTR_FD writes BTR_FD_ADDR, btr_fd.
  - cycle 4: CFG_RUN writes MODE_ADDR, {24'b0, mode[7:1], 1'b0}.
- WAIT_IDLE:
  - 20-bit down-counter loaded with 11*bit_cycles−1 (unsigned, no overflow) on entry; decrements each cycle.
  - Exits when the counter reaches 0, so it lasts 11*N cycles. If bit_cycles==0, it lasts 1 cycle.
  - Then READY: ready_o=1, cfg_busy_o=0.
- READY + tx_req_i with 1≤tx_len_i≤MAX_TX_BYTES:
  - Latch frame and length; tx_busy_o=1, ready_o=0.
  - TX_LOAD issues tx_we_o on len consecutive cycles, addr 0..len−1, data byte[addr].
  - TX_CMD then writes CMD_ADDR, 32'h1 with tx_ack_o=1 in the same cycle.
  - Next cycle READY.
- Rejections and ignored requests:
  - tx_req_i with len 0 or >MAX_TX_BYTES: err_o pulse next cycle, no writes, stay READY.
  - tx_req_i outside READY: err_o pulse, ignored.
  - cfg_start_i during CFG_*, WAIT_IDLE or TX_*: err_o pulse, ignored.
  - cfg_start_i in READY: reconfigure; ready_o drops next cycle.
  - cfg_start_i and tx_req_i in the same READY cycle: cfg_start wins, and err_o pulses once for the dropped tx_req.
- Mutual exclusion: reg_we_o and tx_we_o are never high in the same cycle. ready_o, cfg_busy_o and tx_busy_o are one-hot or all zero (all zero only in IDLE).

Test Plan:
- Config: rst, cfg_start with btr=0x2A_12_49_1D, btr_fd=0x0A_04_49_1D, mode=0x09, bit_cycles=200 → writes (0,0x1),(6,btr),(7,btr_fd),(0,0x08) on cycles 1–4; ready_o rises exactly 2200 cycles after the cycle-4 write.
- TX load: READY, tx_req with len=13, bytes 0x88,0x12,0x34,0x56,0x78,0x01..0x08 → 13 tx_we_o pulses, addr 0..12 in order; then reg write (1,0x1) with tx_ack_o; READY next cycle.
- Bad length: tx_req with len=0, then len=14 → err_o pulse each; no strobes; ready_o stays 1.
- Collision: cfg_start during WAIT_IDLE → err_o, counter unaffected; simultaneous cfg_start+tx_req in READY → reconfig sequence, exactly one err_o pulse.
- Reset mid-TX: assert rst_i asynchronously after the 5th tx_we_o → all outputs 0 within the same cycle, state IDLE; tx_req afterwards → err_o.
- bit_cycles=0: config completes with ready_o one cycle after the CFG_RUN write.
